// File: rtl/commit_trace_receiver.sv
// ---------------------------------------------------------------------------
// commit_trace_receiver
//
// Receiving end of the core commit/trace interface on the checker side.
// Every cycle it samples the commit, memory-access and exception-event
// signals exported by the core. It merges each commit with its memory
// access into one trace record, gives the record a sequence number, and
// buffers it in a FIFO. The checker drains the FIFO one record at a time.
//
// Handshake: the head record is presented while out_valid is high. It is
// consumed on a rising clock edge where out_valid && out_ready. While
// out_valid && !out_ready every out_* field holds steady. out_ready has no
// effect while the FIFO is empty.
//
// Ports
//   clock, reset            sole clock; synchronous active-high reset
//   in_commit_*             committed instruction (valid, inst word, pc)
//   in_mem_read_*           load access (valid, address, size code)
//   in_mem_write_*          store access (valid, address, data, size code)
//   in_event_*              exception/interrupt (valid, cause, pc)
//   out_valid / out_ready   checker-side handshake for the head record
//   out_seq .. out_cause    head record fields (all zero while empty)
//   level                   FIFO occupancy, 0..DEPTH
//   overflow                sticky: a record was dropped on a full FIFO
//   mem_conflict            sticky: a pending access was overwritten
//   drop_count              dropped-record count, saturating at 0xFFFF
//
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module commit_trace_receiver #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  parameter int SEQW  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  // commit port
  input  logic                     in_commit_valid,
  input  logic [31:0]              in_commit_inst,
  input  logic [XLEN-1:0]          in_commit_pc,
  // load port
  input  logic                     in_mem_read_valid,
  input  logic [XLEN-1:0]          in_mem_read_addr,
  input  logic [2:0]               in_mem_read_width,
  // store port
  input  logic                     in_mem_write_valid,
  input  logic [XLEN-1:0]          in_mem_write_addr,
  input  logic [XLEN-1:0]          in_mem_write_data,
  input  logic [2:0]               in_mem_write_width,
  // exception / interrupt port
  input  logic                     in_event_valid,
  input  logic [XLEN-1:0]          in_event_cause,
  input  logic [XLEN-1:0]          in_event_pc,
  // record output
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEQW-1:0]          out_seq,
  output logic [1:0]               out_kind,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_rd_valid,
  output logic [XLEN-1:0]          out_rd_addr,
  output logic [2:0]               out_rd_width,
  output logic                     out_wr_valid,
  output logic [XLEN-1:0]          out_wr_addr,
  output logic [XLEN-1:0]          out_wr_data,
  output logic [2:0]               out_wr_width,
  output logic [XLEN-1:0]          out_cause,
  // status
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     mem_conflict,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0]  KIND_COMMIT       = 2'd0;
  localparam logic [1:0]  KIND_EVENT        = 2'd1;
  localparam logic [1:0]  KIND_COMMIT_EVENT = 2'd2;

  localparam logic [AW:0]     CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]     FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [SEQW-1:0] SEQ_ONE   = {{(SEQW-1){1'b0}}, 1'b1};
  localparam logic [15:0]     DROP_MAX  = 16'hFFFF;

  // One trace record as stored in the FIFO.
  typedef struct packed {
    logic [SEQW-1:0] seq;
    logic [1:0]      kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            rd_valid;
    logic [XLEN-1:0] rd_addr;
    logic [2:0]      rd_width;
    logic            wr_valid;
    logic [XLEN-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [2:0]      wr_width;
    logic [XLEN-1:0] cause;
  } rec_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  rec_t            r_mem [DEPTH];
  logic [AW:0]     r_wr_cnt;
  logic [AW:0]     r_rd_cnt;
  logic [SEQW-1:0] r_seq;
  logic            r_overflow;
  logic            r_mem_conflict;
  logic [15:0]     r_drop_count;

  // Pending load slot
  logic            r_prd_valid;
  logic [XLEN-1:0] r_prd_addr;
  logic [2:0]      r_prd_width;

  // Pending store slot
  logic            r_pwr_valid;
  logic [XLEN-1:0] r_pwr_addr;
  logic [XLEN-1:0] r_pwr_data;
  logic [2:0]      r_pwr_width;

  // -------------------------------------------------------------------------
  // FIFO bookkeeping
  // -------------------------------------------------------------------------
  logic [AW:0]   w_level;
  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_deq;
  logic          w_gen;
  logic          w_enq;
  logic          w_drop;
  logic          w_mem_only;
  logic          w_conflict;
  rec_t          w_rec;
  rec_t          w_head;

  // The counters carry one extra bit, so full and empty are told apart by
  // their difference and not by pointer equality.
  assign w_level  = r_wr_cnt - r_rd_cnt;
  assign w_wr_ptr = r_wr_cnt[AW-1:0];
  assign w_rd_ptr = r_rd_cnt[AW-1:0];
  assign w_empty  = (w_level == '0);
  assign w_full   = (w_level == FULL_LVL);
  assign w_deq    = !w_empty && out_ready;
  assign w_gen    = in_commit_valid || in_event_valid;
  // A full FIFO still takes a record when the head leaves in the same cycle.
  assign w_enq    = w_gen && (!w_full || w_deq);
  assign w_drop   = w_gen && w_full && !w_deq;

  // An access goes into its pending slot only in a cycle with no commit and
  // no event.
  assign w_mem_only = !in_commit_valid && !in_event_valid;
  assign w_conflict = w_mem_only &&
                      ((in_mem_read_valid  && r_prd_valid) ||
                       (in_mem_write_valid && r_pwr_valid));

  // -------------------------------------------------------------------------
  // Record assembly
  // -------------------------------------------------------------------------
  always_comb begin
    w_rec     = '0;
    w_rec.seq = r_seq;
    if (in_commit_valid) begin
      w_rec.kind = in_event_valid ? KIND_COMMIT_EVENT : KIND_COMMIT;
      w_rec.pc   = in_commit_pc;
      w_rec.inst = in_commit_inst;
      // A same-cycle access takes priority over the pending slot.
      if (in_mem_read_valid) begin
        w_rec.rd_valid = 1'b1;
        w_rec.rd_addr  = in_mem_read_addr;
        w_rec.rd_width = in_mem_read_width;
      end else if (r_prd_valid) begin
        w_rec.rd_valid = 1'b1;
        w_rec.rd_addr  = r_prd_addr;
        w_rec.rd_width = r_prd_width;
      end
      if (in_mem_write_valid) begin
        w_rec.wr_valid = 1'b1;
        w_rec.wr_addr  = in_mem_write_addr;
        w_rec.wr_data  = in_mem_write_data;
        w_rec.wr_width = in_mem_write_width;
      end else if (r_pwr_valid) begin
        w_rec.wr_valid = 1'b1;
        w_rec.wr_addr  = r_pwr_addr;
        w_rec.wr_data  = r_pwr_data;
        w_rec.wr_width = r_pwr_width;
      end
    end else begin
      // An event alone carries no memory fields and no instruction word.
      w_rec.kind = KIND_EVENT;
      w_rec.pc   = in_event_pc;
    end
    if (in_event_valid) begin
      w_rec.cause = in_event_cause;
    end
  end

  // -------------------------------------------------------------------------
  // Pending memory slots
  // -------------------------------------------------------------------------
  // Any commit consumes both slots. If a same-cycle access took priority,
  // the stale pending entry is discarded too, so it is never attached to a
  // later commit. An event-only cycle leaves both slots intact and ignores
  // any access in that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prd_valid <= 1'b0;
      r_prd_addr  <= '0;
      r_prd_width <= '0;
      r_pwr_valid <= 1'b0;
      r_pwr_addr  <= '0;
      r_pwr_data  <= '0;
      r_pwr_width <= '0;
    end else if (in_commit_valid) begin
      r_prd_valid <= 1'b0;
      r_pwr_valid <= 1'b0;
    end else if (w_mem_only) begin
      if (in_mem_read_valid) begin
        r_prd_valid <= 1'b1;
        r_prd_addr  <= in_mem_read_addr;
        r_prd_width <= in_mem_read_width;
      end
      if (in_mem_write_valid) begin
        r_pwr_valid <= 1'b1;
        r_pwr_addr  <= in_mem_write_addr;
        r_pwr_data  <= in_mem_write_data;
        r_pwr_width <= in_mem_write_width;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequence counter, pointers and status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seq          <= '0;
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_overflow     <= 1'b0;
      r_mem_conflict <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      // Dropped records still use up a number, so the checker can see the gap.
      if (w_gen) begin
        r_seq <= r_seq + SEQ_ONE;
      end
      if (w_enq) begin
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
      end
      if (w_deq) begin
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != DROP_MAX) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end
      if (w_conflict) begin
        r_mem_conflict <= 1'b1;
      end
    end
  end

  // Record storage has no reset. Outputs are masked while empty, so stale
  // entries are never visible.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem[w_wr_ptr] <= w_rec;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign w_head = w_empty ? '0 : r_mem[w_rd_ptr];

  assign out_valid    = !w_empty;
  assign out_seq      = w_head.seq;
  assign out_kind     = w_head.kind;
  assign out_pc       = w_head.pc;
  assign out_inst     = w_head.inst;
  assign out_rd_valid = w_head.rd_valid;
  assign out_rd_addr  = w_head.rd_addr;
  assign out_rd_width = w_head.rd_width;
  assign out_wr_valid = w_head.wr_valid;
  assign out_wr_addr  = w_head.wr_addr;
  assign out_wr_data  = w_head.wr_data;
  assign out_wr_width = w_head.wr_width;
  assign out_cause    = w_head.cause;

  assign level        = w_level;
  assign overflow     = r_overflow;
  assign mem_conflict = r_mem_conflict;
  assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_commit_trace_receiver.sv
// ---------------------------------------------------------------------------
// Testbench for commit_trace_receiver.
// Inputs change 1 ns after each rising edge. The monitor samples on the
// falling edge, so each handshake it sees completes on the next rising edge.
// ---------------------------------------------------------------------------
module tb_commit_trace_receiver;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;
  localparam int SEQW  = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  // Record as the checker sees it on the out_* port
  typedef struct packed {
    logic [SEQW-1:0] seq;
    logic [1:0]      kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            rd_valid;
    logic [XLEN-1:0] rd_addr;
    logic [2:0]      rd_width;
    logic            wr_valid;
    logic [XLEN-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [2:0]      wr_width;
    logic [XLEN-1:0] cause;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic            in_commit_valid;
  logic [31:0]     in_commit_inst;
  logic [XLEN-1:0] in_commit_pc;
  logic            in_mem_read_valid;
  logic [XLEN-1:0] in_mem_read_addr;
  logic [2:0]      in_mem_read_width;
  logic            in_mem_write_valid;
  logic [XLEN-1:0] in_mem_write_addr;
  logic [XLEN-1:0] in_mem_write_data;
  logic [2:0]      in_mem_write_width;
  logic            in_event_valid;
  logic [XLEN-1:0] in_event_cause;
  logic [XLEN-1:0] in_event_pc;
  logic            out_valid;
  logic            out_ready;
  logic [SEQW-1:0] out_seq;
  logic [1:0]      out_kind;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_rd_valid;
  logic [XLEN-1:0] out_rd_addr;
  logic [2:0]      out_rd_width;
  logic            out_wr_valid;
  logic [XLEN-1:0] out_wr_addr;
  logic [XLEN-1:0] out_wr_data;
  logic [2:0]      out_wr_width;
  logic [XLEN-1:0] out_cause;
  logic [LW-1:0]   level;
  logic            overflow;
  logic            mem_conflict;
  logic [15:0]     drop_count;

  commit_trace_receiver #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQW(SEQW)) dut (
    .clock(clock), .reset(reset),
    .in_commit_valid(in_commit_valid), .in_commit_inst(in_commit_inst),
    .in_commit_pc(in_commit_pc),
    .in_mem_read_valid(in_mem_read_valid), .in_mem_read_addr(in_mem_read_addr),
    .in_mem_read_width(in_mem_read_width),
    .in_mem_write_valid(in_mem_write_valid), .in_mem_write_addr(in_mem_write_addr),
    .in_mem_write_data(in_mem_write_data), .in_mem_write_width(in_mem_write_width),
    .in_event_valid(in_event_valid), .in_event_cause(in_event_cause),
    .in_event_pc(in_event_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_kind(out_kind), .out_pc(out_pc), .out_inst(out_inst),
    .out_rd_valid(out_rd_valid), .out_rd_addr(out_rd_addr),
    .out_rd_width(out_rd_width),
    .out_wr_valid(out_wr_valid), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .out_wr_width(out_wr_width),
    .out_cause(out_cause), .level(level), .overflow(overflow),
    .mem_conflict(mem_conflict), .drop_count(drop_count)
  );

  // ---------------- scoreboard state ----------------
  logic [REC_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  // Reference model: pending accesses, next sequence number, and the
  // observable occupancy/flags (cur = after the last edge, nxt = after the
  // coming edge).
  logic [SEQW-1:0] m_seq = '0;
  logic            m_prd_v = 1'b0;
  logic [XLEN-1:0] m_prd_addr = '0;
  logic [2:0]      m_prd_w = '0;
  logic            m_pwr_v = 1'b0;
  logic [XLEN-1:0] m_pwr_addr = '0;
  logic [XLEN-1:0] m_pwr_data = '0;
  logic [2:0]      m_pwr_w = '0;
  int m_occ = 0, m_occ_n = 0;
  int m_drops = 0, m_drops_n = 0;
  logic m_ovf = 1'b0, m_ovf_n = 1'b0;
  logic m_conf = 1'b0, m_conf_n = 1'b0;

  task automatic check(input string name, input logic [REC_W-1:0] act,
                       input logic [REC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t dut_rec();
    rec_t r;
    r.seq = out_seq;           r.kind = out_kind;
    r.pc = out_pc;             r.inst = out_inst;
    r.rd_valid = out_rd_valid; r.rd_addr = out_rd_addr; r.rd_width = out_rd_width;
    r.wr_valid = out_wr_valid; r.wr_addr = out_wr_addr; r.wr_data = out_wr_data;
    r.wr_width = out_wr_width; r.cause = out_cause;
    return r;
  endfunction

  // Works out what the coming edge does, from the rules of the trace port.
  task automatic model_step();
    rec_t rec;
    bit   deq;
    m_occ_n = m_occ; m_ovf_n = m_ovf; m_conf_n = m_conf; m_drops_n = m_drops;
    if (reset) begin
      exp_q.delete();
      m_seq = '0; m_prd_v = 0; m_pwr_v = 0;
      m_occ_n = 0; m_ovf_n = 0; m_conf_n = 0; m_drops_n = 0;
      return;
    end
    deq = (m_occ > 0) && out_ready;
    m_occ_n = m_occ - (deq ? 1 : 0);
    if (in_commit_valid || in_event_valid) begin
      rec = '0;
      rec.seq = m_seq;
      m_seq = m_seq + 1;
      if (in_commit_valid) begin
        rec.kind = in_event_valid ? 2'd2 : 2'd0;
        rec.pc = in_commit_pc;
        rec.inst = in_commit_inst;
        if (in_mem_read_valid) begin
          rec.rd_valid = 1; rec.rd_addr = in_mem_read_addr; rec.rd_width = in_mem_read_width;
        end else if (m_prd_v) begin
          rec.rd_valid = 1; rec.rd_addr = m_prd_addr; rec.rd_width = m_prd_w;
        end
        if (in_mem_write_valid) begin
          rec.wr_valid = 1; rec.wr_addr = in_mem_write_addr;
          rec.wr_data = in_mem_write_data; rec.wr_width = in_mem_write_width;
        end else if (m_pwr_v) begin
          rec.wr_valid = 1; rec.wr_addr = m_pwr_addr;
          rec.wr_data = m_pwr_data; rec.wr_width = m_pwr_w;
        end
        m_prd_v = 0;
        m_pwr_v = 0;
      end else begin
        rec.kind = 2'd1;
        rec.pc = in_event_pc;
      end
      if (in_event_valid) rec.cause = in_event_cause;
      if (m_occ < DEPTH || deq) begin
        exp_q.push_back(rec);
        m_occ_n = m_occ_n + 1;
      end else begin
        m_ovf_n = 1;
        if (m_drops_n < 65535) m_drops_n = m_drops_n + 1;
      end
    end else begin
      if (in_mem_read_valid) begin
        if (m_prd_v) m_conf_n = 1;
        m_prd_v = 1; m_prd_addr = in_mem_read_addr; m_prd_w = in_mem_read_width;
      end
      if (in_mem_write_valid) begin
        if (m_pwr_v) m_conf_n = 1;
        m_pwr_v = 1; m_pwr_addr = in_mem_write_addr;
        m_pwr_data = in_mem_write_data; m_pwr_w = in_mem_write_width;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Run one clock: model the coming edge, wait for it, then advance the model.
  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    m_occ = m_occ_n; m_ovf = m_ovf_n; m_conf = m_conf_n; m_drops = m_drops_n;
  endtask

  task automatic idle();
    in_commit_valid = 0; in_mem_read_valid = 0; in_mem_write_valid = 0;
    in_event_valid = 0;
  endtask

  task automatic drive_commit(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    in_commit_valid = 1; in_commit_pc = pc; in_commit_inst = inst;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      check("level", REC_W'(level), REC_W'(m_occ));
      check("out_valid", REC_W'(out_valid), REC_W'(m_occ != 0));
      check("overflow", REC_W'(overflow), REC_W'(m_ovf));
      check("mem_conflict", REC_W'(mem_conflict), REC_W'(m_conf));
      check("drop_count", REC_W'(drop_count), REC_W'(m_drops));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_record: got seq %0d, expected no record", out_seq);
        end else begin
          check("head_record", dut_rec(), exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_fields", dut_rec(), '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int bias;
    reset = 1; out_ready = 0;
    idle();
    in_commit_inst = '0; in_commit_pc = '0;
    in_mem_read_addr = '0; in_mem_read_width = '0;
    in_mem_write_addr = '0; in_mem_write_data = '0; in_mem_write_width = '0;
    in_event_cause = '0; in_event_pc = '0;
    step();
    step();
    reset = 0;
    mon_en = 1;

    // Reset state
    check("rst_level", REC_W'(level), '0);
    check("rst_valid", REC_W'(out_valid), '0);
    check("rst_flags", REC_W'({overflow, mem_conflict, drop_count}), '0);

    // Single commit, one-cycle latency
    out_ready = 1;
    drive_commit(64'h8000_0000, 32'h0000_0013);
    step();
    check("t1_valid", REC_W'(out_valid), REC_W'(1));
    check("t1_seq", REC_W'(out_seq), '0);
    check("t1_kind", REC_W'(out_kind), '0);
    check("t1_mem", REC_W'({out_rd_valid, out_wr_valid}), '0);
    idle();
    step();
    check("t1_level_after", REC_W'(level), '0);

    // Pending store attaches to a later commit, then is consumed
    in_mem_write_valid = 1; in_mem_write_addr = 64'h1000;
    in_mem_write_data = 64'hAB; in_mem_write_width = 3'd3;
    step();
    idle(); step();
    drive_commit(64'h8000_0004, 32'h0000_0013);
    step();
    check("t2_wr_valid", REC_W'(out_wr_valid), REC_W'(1));
    check("t2_wr_addr", REC_W'(out_wr_addr), REC_W'(64'h1000));
    check("t2_wr_data", REC_W'(out_wr_data), REC_W'(64'hAB));
    check("t2_wr_width", REC_W'(out_wr_width), REC_W'(3));
    drive_commit(64'h8000_0008, 32'h0000_0013);
    step();
    check("t2_next_wr_valid", REC_W'(out_wr_valid), '0);

    // Two loads before a commit: conflict, last one wins
    idle();
    in_mem_read_valid = 1; in_mem_read_addr = 64'h2000; in_mem_read_width = 3'd2;
    step();
    in_mem_read_addr = 64'h3000;
    step();
    check("t3_conflict", REC_W'(mem_conflict), REC_W'(1));
    idle();
    drive_commit(64'h8000_000C, 32'h0000_0003);
    step();
    check("t3_rd_valid", REC_W'(out_rd_valid), REC_W'(1));
    check("t3_rd_addr", REC_W'(out_rd_addr), REC_W'(64'h3000));

    // Commit+event, then event alone
    idle();
    drive_commit(64'h8000_0010, 32'h0000_0073);
    in_event_valid = 1; in_event_cause = 64'd2; in_event_pc = 64'h8000_0010;
    step();
    check("t4_kind2", REC_W'(out_kind), REC_W'(2));
    check("t4_cause2", REC_W'(out_cause), REC_W'(2));
    idle();
    in_event_valid = 1; in_event_cause = 64'h8000_0000_0000_0007;
    in_event_pc = 64'h8000_0010;
    step();
    check("t4_kind1", REC_W'(out_kind), REC_W'(1));
    check("t4_inst0", REC_W'(out_inst), '0);
    check("t4_pc", REC_W'(out_pc), REC_W'(64'h8000_0010));
    check("t4_cause", REC_W'(out_cause), REC_W'(64'h8000_0000_0000_0007));
    idle(); step();

    // Overflow: DEPTH+2 commits with the checker stalled
    do_reset();
    out_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle();
      drive_commit(64'h8000_1000 + 64'(4 * i), 32'h0000_0013 + 32'(i));
      step();
    end
    idle();
    check("t5_level", REC_W'(level), REC_W'(8));
    check("t5_overflow", REC_W'(overflow), REC_W'(1));
    check("t5_drops", REC_W'(drop_count), REC_W'(2));
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t5_drain_seq", REC_W'(out_seq), REC_W'(i));
      step();
    end
    drive_commit(64'h8000_2000, 32'h0000_0013);
    step();
    check("t5_seq_after_gap", REC_W'(out_seq), REC_W'(10));
    idle(); step();

    // Full FIFO with a same-cycle dequeue, then reset mid-drain
    do_reset();
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      drive_commit(64'h8000_3000 + 64'(4 * i), 32'h0000_0013);
      step();
    end
    drive_commit(64'h8000_3100, 32'h0000_0013);
    out_ready = 1;
    step();
    check("t6_level_full", REC_W'(level), REC_W'(8));
    check("t6_no_drop", REC_W'({overflow, drop_count}), '0);
    idle();
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    check("t6_rst_valid", REC_W'(out_valid), '0);
    check("t6_rst_level", REC_W'(level), '0);

    // Randomized traffic; occasional resets
    bias = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) bias = $urandom_range(10, 95);
      idle();
      out_ready = ($urandom_range(0, 99) < bias);
      in_commit_valid = ($urandom_range(0, 99) < 40);
      in_event_valid = ($urandom_range(0, 99) < 10);
      in_commit_pc = {$urandom, $urandom};
      in_commit_inst = $urandom;
      in_event_cause = {$urandom, $urandom};
      in_event_pc = {$urandom, $urandom};
      if (!(in_event_valid && !in_commit_valid)) begin
        in_mem_read_valid = ($urandom_range(0, 99) < 25);
        in_mem_write_valid = ($urandom_range(0, 99) < 25);
      end
      in_mem_read_addr = {$urandom, $urandom};
      in_mem_read_width = 3'($urandom_range(0, 7));
      in_mem_write_addr = {$urandom, $urandom};
      in_mem_write_data = {$urandom, $urandom};
      in_mem_write_width = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 799) == 0);
      step();
      reset = 0;
    end

    // Drain and confirm every expected record was delivered
    idle();
    out_ready = 1;
    for (int i = 0; i < DEPTH + 4; i++) step();
    check("final_queue_empty", REC_W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
